// File: rtl/apb_to_wb_bridge_if.sv
// Bus bundle for the APB-to-Wishbone bridge.
// Carries the APB slave-side signals (psel..pslverr) and the Wishbone
// master-side signals (wb_*), using the original port names.
//   slave  : bridge view (APB slave, Wishbone master)
//   master : environment view (APB master, Wishbone slave)
interface apb_to_wb_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    // APB
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;
    // Wishbone
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [STRB_WIDTH-1:0] wb_sel_o;
    logic                  wb_we_o;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic [2:0]            wb_cti_o;
    logic [1:0]            wb_bte_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/apb_to_wb_bridge.sv
// APB slave to Wishbone classic master bridge.
// Each APB transfer becomes one Wishbone classic cycle, with retry on
// wb_rty_i (up to MAX_RETRY), a per-attempt timeout (TIMEOUT cycles) and
// error reporting through pslverr. APB wait states are held until the
// single-cycle DONE response.
// Ports:
//   pclk     : clock
//   preset_n : asynchronous active-low reset
//   bus      : apb_to_wb_bridge_if.slave (APB slave + Wishbone master)
module apb_to_wb_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    apb_to_wb_bridge_if.slave        bus
);
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WB_REQ     = 2'd1;
    localparam logic [1:0] S_RETRY_WAIT = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

    logic [1:0]            state_q,   state_d;
    logic [TW-1:0]         tmo_q,     tmo_d;
    logic [RW-1:0]         rty_q,     rty_d;
    logic [ADDR_WIDTH-1:0] adr_q,     adr_d;
    logic [DATA_WIDTH-1:0] dat_q,     dat_d;
    logic [STRB_WIDTH-1:0] sel_q,     sel_d;
    logic                  we_q,      we_d;
    logic                  cyc_q,     cyc_d;
    logic                  pready_q,  pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        rty_d     = rty_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        pslverr_d = 1'b0;
        prdata_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    adr_d = bus.paddr;
                    we_d  = bus.pwrite;
                    dat_d = bus.pwrite ? bus.pwdata : '0;
                    sel_d = bus.pwrite ? bus.pstrb  : '1;
                    tmo_d = '0;
                    rty_d = '0;
                    // A write with no byte lanes enabled completes locally.
                    if (bus.pwrite && (bus.pstrb == '0)) state_d = S_DONE;
                    else                                 state_d = S_WB_REQ;
                end
            end
            S_WB_REQ: begin
                if (!bus.psel) begin
                    state_d = S_IDLE;
                end else if (bus.wb_err_i) begin
                    state_d   = S_DONE;
                    pslverr_d = 1'b1;
                end else if (bus.wb_ack_i) begin
                    state_d  = S_DONE;
                    prdata_d = we_q ? '0 : bus.wb_dat_i;
                end else if (bus.wb_rty_i) begin
                    if (rty_q < RTY_MAX) begin
                        rty_d   = rty_q + RW'(1);
                        state_d = S_RETRY_WAIT;
                    end else begin
                        state_d   = S_DONE;
                        pslverr_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_DONE;
                    pslverr_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RETRY_WAIT: begin
                tmo_d   = '0;
                state_d = bus.psel ? S_WB_REQ : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rty_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the FSM enters the corresponding state.
        cyc_d    = (state_d == S_WB_REQ);
        pready_d = (state_d == S_DONE);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            rty_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            rty_q     <= rty_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign bus.pready   = pready_q;
    assign bus.pslverr  = pslverr_q;
    assign bus.prdata   = prdata_q;
    assign bus.wb_adr_o = adr_q;
    assign bus.wb_dat_o = dat_q;
    assign bus.wb_sel_o = sel_q;
    assign bus.wb_we_o  = we_q;
    assign bus.wb_cyc_o = cyc_q;
    assign bus.wb_stb_o = cyc_q;
    assign bus.wb_cti_o = 3'b000;
    assign bus.wb_bte_o = 2'b00;
endmodule

// File: tb/tb_apb_to_wb_bridge.sv
// Directed testbench for apb_to_wb_bridge.
module tb_apb_to_wb_bridge;
    logic pclk;
    logic preset_n;
    int   passed;
    int   total;

    apb_to_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();

    apb_to_wb_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STRB_WIDTH(4),
        .TIMEOUT(255),
        .MAX_RETRY(3)
    ) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .bus(bus)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic bus_quiet();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        bus_quiet();
        tick(); tick();
        total++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) $display("FAIL rst_cyc_stb: got %b%b want 00", bus.wb_cyc_o, bus.wb_stb_o); else passed++;
        total++; if (bus.pready !== 1'b0 || bus.pslverr !== 1'b0) $display("FAIL rst_pready_pslverr: got %b%b want 00", bus.pready, bus.pslverr); else passed++;
        total++; if (bus.prdata !== 32'h0) $display("FAIL rst_prdata: got %h want 0", bus.prdata); else passed++;
        total++; if (bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0) $display("FAIL rst_adr_dat: got %h %h want 0 0", bus.wb_adr_o, bus.wb_dat_o); else passed++;
        total++; if (bus.wb_sel_o !== 4'h0 || bus.wb_we_o !== 1'b0) $display("FAIL rst_sel_we: got %h %b want 0 0", bus.wb_sel_o, bus.wb_we_o); else passed++;
        total++; if (bus.wb_cti_o !== 3'b000 || bus.wb_bte_o !== 2'b00) $display("FAIL rst_cti_bte: got %b %b want 000 00", bus.wb_cti_o, bus.wb_bte_o); else passed++;
        preset_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h100; bus.pwdata = 32'hDEADBEEF; bus.pstrb = 4'hF;
        tick();
        bus.penable = 1'b1; bus.wb_ack_i = 1'b1;
        total++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1) $display("FAIL wr_cyc_stb: got %b%b want 11", bus.wb_cyc_o, bus.wb_stb_o); else passed++;
        total++; if (bus.wb_adr_o !== 32'h100) $display("FAIL wr_adr: got %h want 00000100", bus.wb_adr_o); else passed++;
        total++; if (bus.wb_dat_o !== 32'hDEADBEEF) $display("FAIL wr_dat: got %h want deadbeef", bus.wb_dat_o); else passed++;
        total++; if (bus.wb_sel_o !== 4'hF || bus.wb_we_o !== 1'b1) $display("FAIL wr_sel_we: got %h %b want f 1", bus.wb_sel_o, bus.wb_we_o); else passed++;
        total++; if (bus.pready !== 1'b0) $display("FAIL wr_wait_state: got %b want 0", bus.pready); else passed++;
        tick();
        bus.wb_ack_i = 1'b0;
        total++; if (bus.pready !== 1'b1 || bus.pslverr !== 1'b0) $display("FAIL wr_done: got pready=%b pslverr=%b want 1 0", bus.pready, bus.pslverr); else passed++;
        total++; if (bus.prdata !== 32'h0 || bus.wb_cyc_o !== 1'b0) $display("FAIL wr_done_prdata_cyc: got %h %b want 0 0", bus.prdata, bus.wb_cyc_o); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0;
        total++; if (bus.pready !== 1'b0) $display("FAIL wr_pready_single: got %b want 0", bus.pready); else passed++;
    endtask

    task automatic test_read_wait();
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 32'h204; bus.pwdata = 32'hFFFF0000; bus.pstrb = 4'h0;
        tick();
        bus.penable = 1'b1;
        total++; if (bus.wb_sel_o !== 4'hF || bus.wb_we_o !== 1'b0) $display("FAIL rd_sel_we: got %h %b want f 0", bus.wb_sel_o, bus.wb_we_o); else passed++;
        total++; if (bus.wb_adr_o !== 32'h204 || bus.wb_dat_o !== 32'h0) $display("FAIL rd_adr_dat: got %h %h want 00000204 0", bus.wb_adr_o, bus.wb_dat_o); else passed++;
        tick();
        total++; if (bus.wb_cyc_o !== 1'b1 || bus.pready !== 1'b0) $display("FAIL rd_hold: got cyc=%b pready=%b want 1 0", bus.wb_cyc_o, bus.pready); else passed++;
        tick();
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h12345678;
        total++; if (bus.wb_cyc_o !== 1'b1 || bus.pready !== 1'b0) $display("FAIL rd_hold3: got cyc=%b pready=%b want 1 0", bus.wb_cyc_o, bus.pready); else passed++;
        tick();
        bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h55555555;
        total++; if (bus.pready !== 1'b1 || bus.pslverr !== 1'b0) $display("FAIL rd_done: got pready=%b pslverr=%b want 1 0", bus.pready, bus.pslverr); else passed++;
        total++; if (bus.prdata !== 32'h12345678) $display("FAIL rd_prdata: got %h want 12345678", bus.prdata); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.wb_dat_i = '0;
        total++; if (bus.pready !== 1'b0 || bus.prdata !== 32'h0) $display("FAIL rd_after: got pready=%b prdata=%h want 0 0", bus.pready, bus.prdata); else passed++;
    endtask

    task automatic test_retry();
        int attempts;
        attempts = 0;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h300;
        bus.wb_dat_i = 32'hA5A5A5A5;
        tick();
        bus.penable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bus.wb_cyc_o === 1'b1) attempts++;
            bus.wb_rty_i = 1'b1;
            tick();
            bus.wb_rty_i = 1'b0;
            if (k < 3) begin
                total++; if (bus.wb_cyc_o !== 1'b0 || bus.pready !== 1'b0) $display("FAIL rty_gap%0d: got cyc=%b pready=%b want 0 0", k, bus.wb_cyc_o, bus.pready); else passed++;
                tick();
            end
        end
        total++; if (attempts !== 4) $display("FAIL rty_attempts: got %0d want 4", attempts); else passed++;
        total++; if (bus.pready !== 1'b1 || bus.pslverr !== 1'b1) $display("FAIL rty_done: got pready=%b pslverr=%b want 1 1", bus.pready, bus.pslverr); else passed++;
        total++; if (bus.prdata !== 32'h0 || bus.wb_cyc_o !== 1'b0) $display("FAIL rty_prdata_cyc: got %h %b want 0 0", bus.prdata, bus.wb_cyc_o); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.wb_dat_i = '0;
    endtask

    task automatic test_timeout();
        int cycles;
        cycles = 0;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h400; bus.pwdata = 32'h0BADF00D; bus.pstrb = 4'h3;
        tick();
        bus.penable = 1'b1;
        while (bus.wb_cyc_o === 1'b1 && cycles < 400) begin
            cycles++;
            tick();
        end
        total++; if (cycles !== 255) $display("FAIL tmo_cycles: got %0d want 255", cycles); else passed++;
        total++; if (bus.pready !== 1'b1 || bus.pslverr !== 1'b1) $display("FAIL tmo_done: got pready=%b pslverr=%b want 1 1", bus.pready, bus.pslverr); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic test_err_ack();
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h500;
        tick();
        bus.penable = 1'b1; bus.wb_err_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hAAAA5555;
        tick();
        bus.wb_err_i = 1'b0; bus.wb_ack_i = 1'b0;
        total++; if (bus.pready !== 1'b1 || bus.pslverr !== 1'b1) $display("FAIL err_done: got pready=%b pslverr=%b want 1 1", bus.pready, bus.pslverr); else passed++;
        total++; if (bus.prdata !== 32'h0 || bus.wb_cyc_o !== 1'b0) $display("FAIL err_prdata_cyc: got %h %b want 0 0", bus.prdata, bus.wb_cyc_o); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.wb_dat_i = '0;
        total++; if (bus.pslverr !== 1'b0) $display("FAIL err_clear: got %b want 0", bus.pslverr); else passed++;
    endtask

    task automatic test_zero_strb();
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h600; bus.pwdata = 32'h11111111; bus.pstrb = 4'h0;
        tick();
        bus.penable = 1'b1;
        total++; if (bus.pready !== 1'b1 || bus.pslverr !== 1'b0) $display("FAIL zs_done: got pready=%b pslverr=%b want 1 0", bus.pready, bus.pslverr); else passed++;
        total++; if (bus.wb_cyc_o !== 1'b0) $display("FAIL zs_no_cyc: got %b want 0", bus.wb_cyc_o); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0;
        total++; if (bus.pready !== 1'b0 || bus.wb_cyc_o !== 1'b0) $display("FAIL zs_after: got pready=%b cyc=%b want 0 0", bus.pready, bus.wb_cyc_o); else passed++;
    endtask

    task automatic test_abort();
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h700;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0;
        tick();
        total++; if (bus.wb_cyc_o !== 1'b0 || bus.pready !== 1'b0) $display("FAIL abort_drop: got cyc=%b pready=%b want 0 0", bus.wb_cyc_o, bus.pready); else passed++;
        tick();
        total++; if (bus.pready !== 1'b0 || bus.wb_cyc_o !== 1'b0) $display("FAIL abort_idle: got pready=%b cyc=%b want 0 0", bus.pready, bus.wb_cyc_o); else passed++;
    endtask

    task automatic test_back_to_back();
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h800; bus.pwdata = 32'h01020304; bus.pstrb = 4'h5;
        tick();
        bus.penable = 1'b1; bus.wb_ack_i = 1'b1;
        total++; if (bus.wb_sel_o !== 4'h5) $display("FAIL b2b_sel: got %h want 5", bus.wb_sel_o); else passed++;
        tick();
        bus.wb_ack_i = 1'b0;
        total++; if (bus.pready !== 1'b1) $display("FAIL b2b_wr_done: got %b want 1", bus.pready); else passed++;
        tick();
        bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h804;
        tick();
        bus.penable = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hFEEDFACE;
        total++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h804) $display("FAIL b2b_rd_req: got cyc=%b adr=%h want 1 00000804", bus.wb_cyc_o, bus.wb_adr_o); else passed++;
        tick();
        bus.wb_ack_i = 1'b0;
        total++; if (bus.pready !== 1'b1 || bus.prdata !== 32'hFEEDFACE) $display("FAIL b2b_rd_done: got pready=%b prdata=%h want 1 feedface", bus.pready, bus.prdata); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.wb_dat_i = '0;
    endtask

    task automatic test_reset_mid();
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h900; bus.pwdata = 32'h77778888; bus.pstrb = 4'hF;
        tick();
        bus.penable = 1'b1;
        total++; if (bus.wb_cyc_o !== 1'b1) $display("FAIL rm_cyc_before: got %b want 1", bus.wb_cyc_o); else passed++;
        preset_n = 1'b0;
        #1;
        total++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) $display("FAIL rm_cyc_stb: got %b%b want 00", bus.wb_cyc_o, bus.wb_stb_o); else passed++;
        total++; if (bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0 || bus.wb_sel_o !== 4'h0 || bus.wb_we_o !== 1'b0) $display("FAIL rm_wb_out: got %h %h %h %b want 0 0 0 0", bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o); else passed++;
        bus_quiet();
        tick();
        preset_n = 1'b1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'hA00;
        tick();
        bus.penable = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFEF00D;
        total++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'hA00) $display("FAIL rm_rd_req: got cyc=%b adr=%h want 1 00000a00", bus.wb_cyc_o, bus.wb_adr_o); else passed++;
        tick();
        bus.wb_ack_i = 1'b0;
        total++; if (bus.pready !== 1'b1 || bus.prdata !== 32'hCAFEF00D || bus.pslverr !== 1'b0) $display("FAIL rm_rd_done: got pready=%b prdata=%h pslverr=%b want 1 cafef00d 0", bus.pready, bus.prdata, bus.pslverr); else passed++;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.wb_dat_i = '0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_write();
        test_read_wait();
        test_retry();
        test_timeout();
        test_err_ack();
        test_zero_strb();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
